// File: rtl/sprite_line_composer.sv
// Consumer side of the sprite line buffer: scans the composer half out as a pixel stream, then erases it.
// Build option: define SPRITE_COMPOSER_HSCALE_EN for 2x horizontal pixel doubling.
module sprite_line_composer #(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned ERASE_CYCLES = 161
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_ce,
    input  logic        line_start,
    input  logic        swap_req,
    output logic        active_render_buffer,
    output logic        swap_done,
    output logic [9:0]  composer_rd_idx,
    input  logic [15:0] composer_rd_data,
    output logic        composer_erase_start,
    output logic        px_valid,
    output logic [15:0] px_data,
    output logic        px_opaque,
    output logic        busy,
    output logic        line_overrun
);

    localparam int unsigned IDX_W = 10;
    localparam int unsigned CNT_W = (ERASE_CYCLES > 2) ? $clog2(ERASE_CYCLES) : 1;
`ifdef SPRITE_COMPOSER_HSCALE_EN
    localparam int unsigned LAST_IDX = LINE_WIDTH / 2 - 1;
`else
    localparam int unsigned LAST_IDX = LINE_WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ERASE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_q, arb_d;
    logic             pend_q, pend_d;
    logic             swap_done_q, swap_done_d;
    logic             erase_start_q, erase_start_d;
    logic             px_valid_q, px_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             adv_c;
    logic             swap_apply_c;
`ifdef SPRITE_COMPOSER_HSCALE_EN
    logic             phase_q, phase_d;
`endif

    // Next-state, scan addressing, erase countdown and swap arbitration
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        arb_d         = arb_q;
        pend_d        = pend_q;
        swap_done_d   = 1'b0;
        erase_start_d = 1'b0;
        px_valid_d    = 1'b0;
        overrun_d     = 1'b0;
        swap_apply_c  = 1'b0;
`ifdef SPRITE_COMPOSER_HSCALE_EN
        phase_d       = phase_q;
        adv_c         = phase_q;
`else
        adv_c         = 1'b1;
`endif

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
`ifdef SPRITE_COMPOSER_HSCALE_EN
                    phase_d = 1'b0;
`endif
                end
            end
            S_SCAN: begin
                if (line_start) begin
                    idx_d   = '0;
`ifdef SPRITE_COMPOSER_HSCALE_EN
                    phase_d = 1'b0;
`endif
                end else if (pixel_ce) begin
                    px_valid_d = 1'b1;
`ifdef SPRITE_COMPOSER_HSCALE_EN
                    phase_d    = ~phase_q;
`endif
                    if (adv_c) begin
                        // Last word holds its index; the erase starts on the following clock
                        if (idx_q == IDX_W'(LAST_IDX)) begin
                            state_d       = S_ERASE;
                            cnt_d         = CNT_W'(ERASE_CYCLES - 1);
                            erase_start_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            S_ERASE: begin
                overrun_d = line_start;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A swap only lands on an idle clock that is not starting a new line
        swap_apply_c = (state_q == S_IDLE) && !line_start && (swap_req || pend_q);
        if (swap_apply_c) begin
            arb_d       = ~arb_q;
            swap_done_d = 1'b1;
            pend_d      = 1'b0;
        end else if (swap_req) begin
            pend_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            arb_q         <= 1'b0;
            pend_q        <= 1'b0;
            swap_done_q   <= 1'b0;
            erase_start_q <= 1'b0;
            px_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef SPRITE_COMPOSER_HSCALE_EN
            phase_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            arb_q         <= arb_d;
            pend_q        <= pend_d;
            swap_done_q   <= swap_done_d;
            erase_start_q <= erase_start_d;
            px_valid_q    <= px_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
`ifdef SPRITE_COMPOSER_HSCALE_EN
            phase_q       <= phase_d;
`endif
        end
    end

    // Read data arrives one clock after the address, aligned with the registered strobe
    assign px_opaque = px_valid_q && (composer_rd_data != 16'h0000);
    assign px_data   = px_opaque ? composer_rd_data : 16'h0000;

    assign active_render_buffer = arb_q;
    assign swap_done            = swap_done_q;
    assign composer_rd_idx      = idx_q;
    assign composer_erase_start = erase_start_q;
    assign px_valid             = px_valid_q;
    assign busy                 = busy_q;
    assign line_overrun         = overrun_q;

endmodule

// File: tb/tb_sprite_line_composer.sv
// Self-checking bench for sprite_line_composer: random line contents and pixel_ce patterns
// compared against an expected pixel list derived from the line buffer contents.
module tb_sprite_line_composer;

    localparam int LW          = 640;
    localparam int EC          = 161;
    localparam int RESTART_IDX = 100;
`ifdef SPRITE_COMPOSER_HSCALE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int NW = LW / REP;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_ce;
    logic        line_start;
    logic        swap_req;
    logic        active_render_buffer;
    logic        swap_done;
    logic [9:0]  composer_rd_idx;
    logic [15:0] composer_rd_data;
    logic        composer_erase_start;
    logic        px_valid;
    logic [15:0] px_data;
    logic        px_opaque;
    logic        busy;
    logic        line_overrun;

    logic [15:0] mem [0:1023];
    logic [16:0] px_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_erase, n_swap, n_ovr, erase_cyc, last_px_cyc, last_busy_cyc;

    sprite_line_composer #(.LINE_WIDTH(LW), .ERASE_CYCLES(EC)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pixel_ce             (pixel_ce),
        .line_start           (line_start),
        .swap_req             (swap_req),
        .active_render_buffer (active_render_buffer),
        .swap_done            (swap_done),
        .composer_rd_idx      (composer_rd_idx),
        .composer_rd_data     (composer_rd_data),
        .composer_erase_start (composer_erase_start),
        .px_valid             (px_valid),
        .px_data              (px_data),
        .px_opaque            (px_opaque),
        .busy                 (busy),
        .line_overrun         (line_overrun)
    );

    always #5 clk = ~clk;

    // Line buffer: synchronous read, one clock of latency
    always @(posedge clk) composer_rd_data <= mem[composer_rd_idx];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (px_valid) begin
            px_q.push_back({px_opaque, px_data});
            last_px_cyc = cyc;
        end
        if (composer_erase_start) begin
            n_erase++;
            erase_cyc = cyc;
        end
        if (swap_done) n_swap++;
        if (line_overrun) n_ovr++;
        if (busy) last_busy_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] px_word(input logic [15:0] w);
        return {(w != 16'h0000), w};
    endfunction

    task automatic clear_mon();
        px_q          = {};
        n_erase       = 0;
        n_swap        = 0;
        n_ovr         = 0;
        erase_cyc     = -1;
        last_px_cyc   = -2;
        last_busy_cyc = -3;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 1024; i++) begin
            case (mode)
                0:       mem[i] = 16'(i + 1);
                1:       mem[i] = 16'h0000;
                default: mem[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            endcase
        end
    endtask

    // period 0 = random pixel_ce, otherwise pixel_ce every period-th clock
    task automatic run_line(input int mode, input int period, input bit do_swap,
                            input bit do_restart, input bit do_ovr);
        logic [16:0] exp_q [$];
        int   guard, ph, n;
        bit   restarted, ovr_done, just_restarted;
        logic old_arb, exp_arb;

        fill(mode);
        exp_q = {};
        if (do_restart)
            for (int k = 0; k < RESTART_IDX; k++)
                for (int r = 0; r < REP; r++) exp_q.push_back(px_word(mem[k]));
        for (int k = 0; k < NW; k++)
            for (int r = 0; r < REP; r++) exp_q.push_back(px_word(mem[k]));

        clear_mon();
        old_arb    = active_render_buffer;
        line_start = 1'b1;
        swap_req   = do_swap;
        tick();
        line_start = 1'b0;
        swap_req   = 1'b0;

        guard = 0; ph = 0; restarted = 0; ovr_done = 0;
        while (busy === 1'b1 && guard < 20000) begin
            line_start     = 1'b0;
            swap_req       = 1'b0;
            just_restarted = 1'b0;
            if (period == 0) pixel_ce = 1'($urandom_range(0, 1));
            else begin
                pixel_ce = (ph == 0);
                ph = (ph + 1) % period;
            end
            if (do_swap && (guard == 50 || guard == 57)) swap_req = 1'b1;
            if (do_restart && !restarted && composer_rd_idx == 10'(RESTART_IDX)) begin
                line_start     = 1'b1;
                pixel_ce       = 1'b0;
                restarted      = 1'b1;
                just_restarted = 1'b1;
            end
            if (do_ovr && !ovr_done && n_erase == 1 && cyc == erase_cyc + 20) begin
                line_start = 1'b1;
                ovr_done   = 1'b1;
            end
            tick();
            guard++;
            if (just_restarted) check("restart_idx", composer_rd_idx, 0);
        end
        check("timeout", guard < 20000, 1);
        check("arb_held_busy", active_render_buffer, old_arb);
        line_start = 1'b0;
        swap_req   = 1'b0;
        pixel_ce   = 1'b0;
        repeat (5) tick();

        check("px_count", px_q.size(), exp_q.size());
        n = (px_q.size() < exp_q.size()) ? px_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("px[%0d]", i), px_q[i], exp_q[i]);
        check("erase_cnt", n_erase, 1);
        check("erase_after_last", erase_cyc, last_px_cyc);
        check("busy_fall", last_busy_cyc + 1 - erase_cyc, EC);
        check("overrun", n_ovr, do_ovr);
        exp_arb = do_swap ? ~old_arb : old_arb;
        check("swap_arb", active_render_buffer, exp_arb);
        check("swap_done_cnt", n_swap, do_swap);
    endtask

    task automatic reset_mid_scan();
        int guard;
        fill(0);
        clear_mon();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        guard = 0;
        while (composer_rd_idx != 10'd300 && guard < 5000) begin
            pixel_ce = 1'b1;
            swap_req = (guard == 10);
            tick();
            guard++;
        end
        pixel_ce = 1'b0;
        swap_req = 1'b0;
        check("rst_reach_timeout", guard < 5000, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_idx", composer_rd_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_px_valid", px_valid, 0);
        check("rst_arb", active_render_buffer, 0);
        repeat (200) tick();
        check("rst_no_erase", n_erase, 0);
        check("rst_no_swap", n_swap, 0);
        check("rst_idle_busy", busy, 0);
    endtask

    initial begin
        logic old_arb, exp_arb;
        rst        = 1'b1;
        pixel_ce   = 1'b0;
        line_start = 1'b0;
        swap_req   = 1'b0;
        fill(1);
        clear_mon();
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        check("init_arb", active_render_buffer, 0);
        check("init_swap_done", swap_done, 0);
        check("init_idx", composer_rd_idx, 0);
        check("init_erase", composer_erase_start, 0);
        check("init_px_valid", px_valid, 0);
        check("init_px_data", px_data, 0);
        check("init_px_opaque", px_opaque, 0);
        check("init_busy", busy, 0);
        check("init_overrun", line_overrun, 0);

        old_arb  = active_render_buffer;
        exp_arb  = ~old_arb;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("idle_swap_arb", active_render_buffer, exp_arb);
        check("idle_swap_done", swap_done, 1);
        tick();
        check("idle_swap_done_clr", swap_done, 0);

        run_line(0, 1, 1'b1, 1'b0, 1'b0);
        run_line(1, 3, 1'b0, 1'b0, 1'b0);
        run_line(2, 1, 1'b0, 1'b1, 1'b1);
        run_line(2, 0, 1'b1, 1'b0, 1'b0);
        run_line(2, 0, 1'b0, 1'b1, 1'b1);
        reset_mid_scan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
